// File: rtl/project_period_counter_slave.sv
// Slave period counter (up/down/up-down) with phase-sync load and daisy-chain sync output.
// o_period/o_dir/o_sync registered, one edge from inputs; no backpressure, i_en=0 or mode 00 holds state.
module project_period_counter_slave #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_period,
  input  logic             i_sync,
  input  logic             i_sync_en,
  input  logic [WIDTH-1:0] i_phase,
  input  logic             i_phase_dir,
  input  logic [1:0]       i_sync_sel,
  input  logic [WIDTH-1:0] i_compare_b,
  output logic [WIDTH-1:0] o_period,
  output logic [WIDTH-1:0] o_period_next,
  output logic             o_dir,
  output logic             o_sync
);

  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  dir_t             dir_q;
  dir_t             dir_d;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] per_q;
  logic [WIDTH-1:0] per_d;
  logic [WIDTH-1:0] ph_sat;
  logic             sync_q;
  logic             sync_evt;
  logic             run;
  logic             sync_cond;

  always_comb begin
    run      = i_en && (i_mode != 2'b00);
    sync_evt = i_sync && !sync_q;
    ph_sat   = (i_phase > i_period) ? i_period : i_phase;
    cnt_d    = o_period;
    dir_d    = dir_q;
    per_d    = per_q;
    if (run && sync_evt && i_sync_en) begin
      // Sync reloads the period too, so the phase is clamped against the incoming period.
      cnt_d = ph_sat;
      per_d = i_period;
      if (i_mode == 2'b01)
        dir_d = UP;
      else if (i_mode == 2'b10)
        dir_d = DOWN;
      else if (i_phase == '0)
        dir_d = UP;
      else if (i_phase >= i_period)
        dir_d = DOWN;
      else
        dir_d = dir_t'(i_phase_dir);
    end else if (run) begin
      case (i_mode)
        2'b01: begin
          dir_d = UP;
          if (o_period >= per_q) begin
            cnt_d = '0;
            per_d = i_period;
          end else begin
            cnt_d = o_period + ONE;
          end
        end
        2'b10: begin
          dir_d = DOWN;
          if (o_period == '0) begin
            cnt_d = i_period;
            per_d = i_period;
          end else begin
            cnt_d = o_period - ONE;
          end
        end
        default: begin
          if (per_q == '0)
            cnt_d = '0;
          else if (dir_q == UP)
            cnt_d = (o_period >= per_q) ? o_period - ONE : o_period + ONE;
          else
            cnt_d = (o_period == '0) ? o_period + ONE : o_period - ONE;
          // Direction follows the new count so 0 and P are each visited once per turn.
          if (cnt_d == '0) begin
            dir_d = UP;
            per_d = i_period;
          end else if (cnt_d == per_q) begin
            dir_d = DOWN;
          end else begin
            dir_d = (cnt_d > o_period) ? UP : DOWN;
          end
        end
      endcase
    end
  end

  always_comb begin
    case (i_sync_sel)
      2'b00:   sync_cond = sync_evt;
      2'b01:   sync_cond = run && (o_period == '0);
      2'b10:   sync_cond = run && (o_period == i_compare_b);
      default: sync_cond = run && (o_period == per_q);
    endcase
  end

  assign o_period_next = i_reset ? '0 : cnt_d;
  assign o_dir         = dir_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_period <= '0;
      dir_q    <= UP;
      per_q    <= i_period;
      sync_q   <= 1'b0;
      o_sync   <= 1'b0;
    end else begin
      o_period <= cnt_d;
      dir_q    <= dir_d;
      per_q    <= per_d;
      sync_q   <= i_sync;
      o_sync   <= sync_cond;
    end
  end

endmodule

// File: doc/project_period_counter_slave.md
PROJECT_PERIOD_COUNTER_SLAVE -- requirements
Module: project_period_counter_slave

Interface
REQ-001 SHALL have parameter: WIDTH, 16, counter/period/phase/compare width.
REQ-002 SHALL have port: i_clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: i_reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: i_en  input  1  count enable; 0 = hold all state.
REQ-005 SHALL have port: i_mode  input  2  00 stop, 01 up, 10 down, 11 up-down.
REQ-006 SHALL have port: i_period  input  WIDTH  requested period (shadow-loaded).
REQ-007 SHALL have port: i_sync  input  1  sync from master o_sync or previous slave.
REQ-008 SHALL have port: i_sync_en  input  1  1 = honour i_sync.
REQ-009 SHALL have port: i_phase  input  WIDTH  count value loaded on sync.
REQ-010 SHALL have port: i_phase_dir  input  1  direction loaded on sync in up-down (0 up, 1 down).
REQ-011 SHALL have port: i_sync_sel  input  2  o_sync source: 00 pass-through, 01 count==0, 10 count==i_compare_b, 11 count==active period.
REQ-012 SHALL have port: i_compare_b  input  WIDTH  compare value for sync_sel 10.
REQ-013 SHALL have port: o_period  output  WIDTH  registered counter value.
REQ-014 SHALL have port: o_period_next  output  WIDTH  combinational value o_period takes next edge.
REQ-015 SHALL have port: o_dir  output  1  current direction (0 up, 1 down).
REQ-016 SHALL have port: o_sync  output  1  registered one-cycle sync for daisy-chaining.

Function
REQ-017 Direction FSM SHALL have states UP and DOWN; up mode forces UP, down mode forces DOWN, up-down toggles at boundaries.
REQ-018 Active period register SHALL load i_period at reset and whenever next count is a boundary-reload (up: wrap to 0; down: reload; up-down: reaching 0).
REQ-019 Up: count 0..P then 0 next cycle (P+1 states).
REQ-020 Down: count P..0 then P next cycle; after reset first value 0 then P.
REQ-021 Up-down: 0,1..P (dir->DOWN at P), P-1..0 (dir->UP at 0); P and 0 each held one cycle.
REQ-022 Sync event SHALL be rising edge of i_sync (registered previous value), so a multi-cycle high level gives one event.
REQ-023 Sync event with i_sync_en=1, i_en=1, mode!=00 SHALL load o_period = min(i_phase, P) next edge, overriding counting; in up-down o_dir loads i_phase_dir, except phase 0 forces UP and phase>=P forces DOWN.
REQ-024 Sync event SHALL also reload active period from i_period.
REQ-025 i_en=0 or mode 00: o_period, o_dir, active period hold; sync events ignored; edge detector still tracks i_sync.
REQ-026 P=0: o_period stays 0 in all run modes, o_dir UP.
REQ-027 Mode change mid-run SHALL take effect next edge from current count; count>P cannot occur (P changes only at reload).
REQ-028 o_sync SHALL be registered, asserted one cycle after o_period satisfies the selected condition with i_en=1 and mode!=00; sel 00 asserts one cycle after the sync event regardless of i_sync_en.
REQ-029 o_period_next SHALL equal o_period when held, else next count value per REQ-019..023.
REQ-030 No arithmetic overflow: up compares to P before increment; down compares to 0 before decrement.

Reset
REQ-031 While i_reset=1 at an edge: o_period=0, o_dir=0, o_sync=0, sync edge register=0, active period=i_period; reset overrides enable and sync.
REQ-032 Reset asserted mid-count SHALL take effect on the next edge; first count after release is 1 (up/up-down) or P (down).

Verification
REQ-033 P=15, mode 01, en=1 after reset -> o_period 0..15,0..15; o_sync (sel 01) high one cycle after each 0.
REQ-034 P=15, mode 11 -> 0..15,14..0,1..; o_dir 1 from count 15 through 1, 0 at 0.
REQ-035 mode 01, count=3, i_sync pulse with i_phase=10 -> o_period 10 next edge, then 11; i_sync held high 5 cycles -> single load.
REQ-036 mode 11, i_phase=20, P=15, i_phase_dir=0 -> o_period=15, o_dir=1, next 14.
REQ-037 i_en=0 for 16 cycles with syncs applied -> o_period unchanged, o_sync=0 (sel 01..11); i_period changed 15->7 mid-count in up mode -> old sequence to 15, then 0..7.
REQ-038 Reset at count 9 in mode 10 -> o_period 0, then 15,14..; sel 10 with i_compare_b=5 -> o_sync one cycle after o_period==5.
